// File: rtl/alu_uart_interface.sv
// Byte-serial front-end for the combinational ALU: collects A, B and opcode from the
// UART receiver, captures the ALU result and hands it to the UART transmitter.
//
// state   | meaning
// WAIT_A  | idle, next received byte is operand A
// WAIT_B  | next received byte is operand B
// WAIT_OP | next received byte is the opcode (validated)
// EXEC    | ALU inputs settled, capture RESULT
// SEND    | TX_START pulse
// WAIT_TX | waiting for the transmitter to finish
module alu_uart_interface #(
  parameter int SIZEDATA = 8,
  parameter int SIZEOP   = 6
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RX_DONE,
  input  logic [SIZEDATA-1:0] RX_DATA,
  input  logic                TX_DONE,
  input  logic [SIZEDATA-1:0] RESULT,
  output logic [SIZEDATA-1:0] DATOA,
  output logic [SIZEDATA-1:0] DATOB,
  output logic [SIZEOP-1:0]   OPCODE,
  output logic                TX_START,
  output logic [SIZEDATA-1:0] TX_DATA,
  output logic                BUSY,
  output logic                ERR
);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
  } state_t;

  localparam logic [SIZEOP-1:0] OP_ADD = SIZEOP'('h20);
  localparam logic [SIZEOP-1:0] OP_SUB = SIZEOP'('h22);
  localparam logic [SIZEOP-1:0] OP_AND = SIZEOP'('h24);
  localparam logic [SIZEOP-1:0] OP_OR  = SIZEOP'('h25);
  localparam logic [SIZEOP-1:0] OP_XOR = SIZEOP'('h26);
  localparam logic [SIZEOP-1:0] OP_NOR = SIZEOP'('h27);
  localparam logic [SIZEOP-1:0] OP_SRL = SIZEOP'('h02);
  localparam logic [SIZEOP-1:0] OP_SRA = SIZEOP'('h03);

  state_t              state_q;
  logic [SIZEDATA-1:0] datoa_q, datob_q, tx_data_q;
  logic [SIZEOP-1:0]   opcode_q;
  logic                tx_start_q, busy_q, err_q;
  logic                op_valid;
  logic [SIZEOP-1:0]   op_byte;

  assign op_byte = RX_DATA[SIZEOP-1:0];

  // Upper bits must be clear so e.g. 0x60 is not mistaken for ADD.
  always_comb begin
    op_valid = 1'b0;
    if (RX_DATA[SIZEDATA-1:SIZEOP] == '0) begin
      case (op_byte)
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_NOR, OP_SRL, OP_SRA: op_valid = 1'b1;
        default:                        op_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= WAIT_A;
      datoa_q    <= '0;
      datob_q    <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        WAIT_A: begin
          busy_q <= 1'b0;
          if (RX_DONE) begin
            datoa_q <= RX_DATA;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          busy_q <= 1'b0;
          if (RX_DONE) begin
            datob_q <= RX_DATA;
            state_q <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          busy_q <= 1'b0;
          if (RX_DONE) begin
            if (op_valid) begin
              opcode_q <= op_byte;
              busy_q   <= 1'b1;
              state_q  <= EXEC;
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_A;
            end
          end
        end
        EXEC: begin
          tx_data_q  <= RESULT;
          tx_start_q <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          busy_q  <= 1'b1;
          state_q <= WAIT_TX;
        end
        WAIT_TX: begin
          if (TX_DONE) begin
            busy_q  <= 1'b0;
            state_q <= WAIT_A;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= WAIT_A;
        end
      endcase
    end
  end

  assign DATOA    = datoa_q;
  assign DATOB    = datob_q;
  assign OPCODE   = opcode_q;
  assign TX_DATA  = tx_data_q;
  assign TX_START = tx_start_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface; a behavioural ALU closes the RESULT loop.
module tb_alu_uart_interface;

  logic       CLK = 1'b0;
  logic       RESET, RX_DONE, TX_DONE;
  logic [7:0] RX_DATA, RESULT, DATOA, DATOB, TX_DATA;
  logic [5:0] OPCODE;
  logic       TX_START, BUSY, ERR;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  always #5 CLK = ~CLK;

  alu_uart_interface #(.SIZEDATA(8), .SIZEOP(6)) dut (
    .CLK(CLK), .RESET(RESET), .RX_DONE(RX_DONE), .RX_DATA(RX_DATA),
    .TX_DONE(TX_DONE), .RESULT(RESULT), .DATOA(DATOA), .DATOB(DATOB),
    .OPCODE(OPCODE), .TX_START(TX_START), .TX_DATA(TX_DATA),
    .BUSY(BUSY), .ERR(ERR)
  );

  always_comb begin
    RESULT = 8'h00;
    case (OPCODE)
      6'h20: RESULT = DATOA + DATOB;
      6'h22: RESULT = DATOA - DATOB;
      6'h24: RESULT = DATOA & DATOB;
      6'h25: RESULT = DATOA | DATOB;
      6'h26: RESULT = DATOA ^ DATOB;
      6'h27: RESULT = ~(DATOA | DATOB);
      6'h02: RESULT = DATOA >> DATOB;
      6'h03: RESULT = 8'($signed(DATOA) >>> DATOB);
      default: RESULT = 8'h00;
    endcase
  end

  always @(posedge CLK) if (TX_START) starts++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_DONE = 1'b1;
    RX_DATA = b;
    @(negedge CLK);
    RX_DONE = 1'b0;
  endtask

  // Three back-to-back bytes; returns in the first WAIT_TX cycle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input logic [7:0] exp);
    @(negedge CLK);
    RX_DONE = 1'b1; RX_DATA = a;
    @(negedge CLK);
    chk({tag, "_datoa"}, DATOA, a);
    RX_DATA = b;
    @(negedge CLK);
    chk({tag, "_datob"}, DATOB, b);
    RX_DATA = op;
    @(negedge CLK);
    RX_DONE = 1'b0;
    chk({tag, "_exec_busy"}, {7'b0, BUSY}, 8'h01);
    chk({tag, "_exec_nostart"}, {7'b0, TX_START}, 8'h00);
    chk({tag, "_opcode"}, {2'b0, OPCODE}, op);
    @(negedge CLK);
    chk({tag, "_send_start"}, {7'b0, TX_START}, 8'h01);
    chk({tag, "_send_data"}, TX_DATA, exp);
    chk({tag, "_send_busy"}, {7'b0, BUSY}, 8'h01);
    @(negedge CLK);
    chk({tag, "_wait_start"}, {7'b0, TX_START}, 8'h00);
    chk({tag, "_wait_busy"}, {7'b0, BUSY}, 8'h01);
    chk({tag, "_wait_data"}, TX_DATA, exp);
  endtask

  task automatic finish_tx(input string tag);
    TX_DONE = 1'b1;
    @(negedge CLK);
    TX_DONE = 1'b0;
    chk({tag, "_idle_busy"}, {7'b0, BUSY}, 8'h00);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_datoa"}, DATOA, 8'h00);
    chk({tag, "_datob"}, DATOB, 8'h00);
    chk({tag, "_opcode"}, {2'b0, OPCODE}, 8'h00);
    chk({tag, "_txdata"}, TX_DATA, 8'h00);
    chk({tag, "_ctrl"}, {5'b0, TX_START, BUSY, ERR}, 8'h00);
  endtask

  initial begin
    int s0;
    RESET = 1'b1; RX_DONE = 1'b0; TX_DONE = 1'b0; RX_DATA = 8'h00;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk_all_zero("reset");

    run_op("add", 8'h07, 8'h02, 8'h20, 8'h09);
    finish_tx("add");
    run_op("sub", 8'h07, 8'h02, 8'h22, 8'h05);
    finish_tx("sub");
    run_op("nor", 8'h07, 8'h02, 8'h27, 8'hF8);
    finish_tx("nor");
    run_op("srl", 8'hF9, 8'h02, 8'h02, 8'h3E);
    finish_tx("srl");
    run_op("sra", 8'hF9, 8'h02, 8'h03, 8'hFE);
    finish_tx("sra");

    // Invalid opcode: ERR pulse, no transmission, OPCODE keeps SRA
    s0 = starts;
    send_byte(8'h07);
    send_byte(8'h02);
    send_byte(8'h21);
    chk("inv_err", {7'b0, ERR}, 8'h01);
    chk("inv_busy", {7'b0, BUSY}, 8'h00);
    chk("inv_opcode", {2'b0, OPCODE}, 8'h03);
    @(negedge CLK);
    chk("inv_err_clr", {7'b0, ERR}, 8'h00);
    repeat (3) @(negedge CLK);
    chk("inv_nostart", 8'(starts - s0), 8'h00);
    run_op("after_inv", 8'h01, 8'h01, 8'h20, 8'h02);

    // Byte arriving in WAIT_TX is dropped
    send_byte(8'h55);
    chk("drop_datoa", DATOA, 8'h01);
    chk("drop_busy", {7'b0, BUSY}, 8'h01);
    finish_tx("drop");
    run_op("and", 8'h03, 8'h04, 8'h24, 8'h00);
    finish_tx("and");

    // Reset with A and B collected
    send_byte(8'h07);
    send_byte(8'h02);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk_all_zero("rst_mid");
    s0 = starts;
    send_byte(8'h20);
    chk("rst_mid_a", DATOA, 8'h20);
    chk("rst_mid_busy", {7'b0, BUSY}, 8'h00);
    repeat (4) @(negedge CLK);
    chk("rst_mid_nostart", 8'(starts - s0), 8'h00);

    // Finish that partial sequence back in a clean state, then reset in WAIT_TX
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    run_op("xor", 8'h0F, 8'h3C, 8'h26, 8'h33);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk_all_zero("rst_wtx");
    s0 = starts;
    TX_DONE = 1'b1;
    @(negedge CLK);
    TX_DONE = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rst_wtx_nostart", 8'(starts - s0), 8'h00);
    chk("rst_wtx_busy", {7'b0, BUSY}, 8'h00);
    run_op("or", 8'h50, 8'h05, 8'h25, 8'h55);
    finish_tx("or");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
